mem_align_unit: RTL and testbench
=================================

MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge.
REQ-002 SHALL have ports: RST_N  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: REQ_VALID  in  1  CPU access request.
REQ-004 SHALL have ports: REQ_READY  out  1  unit can accept a request.
REQ-005 SHALL have ports: REQ_WE  in  1  1 = store, 0 = load.
REQ-006 SHALL have ports: REQ_ADDR  in  32  byte address.
REQ-007 SHALL have ports: REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 SHALL have ports: REQ_UNSIGNED  in  1  zero-extend loads.
REQ-009 SHALL have ports: REQ_WDATA  in  32  store data, LSB-aligned.
REQ-010 SHALL have ports: RSP_VALID  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: RSP_RDATA  out  32  extended load result.
REQ-012 SHALL have ports: RSP_ERR  out  1  illegal size.
REQ-013 SHALL have ports: MEM_ADDR2, MEM_DIN2  out  32; MEM_WRITE2, MEM_READ2, MEM_SIGN  out  1; MEM_SIZE  out  2; MEM_DOUT2  in  32. These form the data-port of the memory. Read data is valid exactly one cycle after MEM_READ2.
REQ-014 Parameter IO_BASE, default 32'h11000000: addresses >= IO_BASE are IO.

Function
REQ-015 SHALL accept a request on REQ_VALID & REQ_READY (cycle T) and latch all REQ_* fields; REQ_READY SHALL be 1 only in state IDLE.
REQ-016 An access SHALL be "spanning" when (size 1 and ADDR[1:0]=3) or (size 2 and ADDR[1:0]!=0); IO accesses are never spanning.
REQ-017 FSM states SHALL be IDLE, RD0, RD1, RD2, WR, WRB, RSP.
REQ-018 Transitions from IDLE on accept:
- load -> RD0
- non-spanning or IO store -> WR
- spanning store -> WRB
- size 3 -> RSP with RSP_ERR=1, RSP_RDATA=0, no memory access.
REQ-019 Non-IO loads SHALL issue aligned word reads only: MEM_SIZE=2, MEM_SIGN=0, MEM_ADDR2={ADDR[31:2],2'b00}.
REQ-020 RD0 SHALL assert MEM_READ2 for word0, then go to RD1.
REQ-021 RD1 SHALL capture MEM_DOUT2 into lo. If spanning, RD1 SHALL also assert MEM_READ2 at word0 address + 4 (mod 2^32) and go to RD2; otherwise it SHALL go to RSP.
REQ-022 RD2 SHALL capture MEM_DOUT2 into hi, then go to RSP.
REQ-023 Load result SHALL be the little-endian bytes {hi,lo} starting at byte ADDR[1:0] of lo, truncated to the access size, then sign- or zero-extended per REQ_UNSIGNED.
REQ-024 IO loads SHALL issue a single read at the unmodified address and return MEM_DOUT2 unmodified.
REQ-025 WR SHALL assert MEM_WRITE2 for one cycle with the original address, size, data and MEM_SIGN=REQ_UNSIGNED, then go to RSP.
REQ-026 WRB SHALL issue N byte stores (N=2 for half, 4 for word), one per cycle, k=0..N-1: MEM_ADDR2=ADDR+k, MEM_SIZE=0, MEM_DIN2[7:0]=WDATA[8k+7:8k], upper bits 0. After k=N-1 it SHALL go to RSP.
REQ-027 RSP SHALL assert RSP_VALID for exactly one cycle with final RSP_RDATA/RSP_ERR (RDATA=0 for stores), then go to IDLE.
REQ-028 Latency from accept T to RSP_VALID:
- non-spanning or IO load T+3; spanning load T+4
- non-spanning store T+2; spanning store T+N+2
- illegal T+1.
REQ-029 MEM_READ2 and MEM_WRITE2 SHALL never be asserted together, and SHALL both be 0 in IDLE and RSP.
REQ-030 MEM_ADDR2 and MEM_DIN2 SHALL be 0 when no access is driven.
REQ-031 A new request SHALL be accepted no earlier than the cycle after RSP (back-to-back throughput = latency + 1).

Reset
REQ-032 While RST_N=0, state SHALL be IDLE and REQ_READY=1. All other outputs and internal registers (lo, hi, byte counter, latched request) SHALL be 0, asynchronously.
REQ-033 Reset asserted mid-operation SHALL abort the access immediately: no further memory strobes and no RSP_VALID for the aborted request.

Verification
REQ-034 Load word at 0x100, mem[0x100]=0x11223344 -> RD0 read 0x100; RSP_VALID at T+3; RDATA=0x11223344.
REQ-035 Signed lw at 0x102, mem[0x100]=0xAABBCCDD, mem[0x104]=0x11223344 -> reads 0x100 then 0x104; RSP at T+4; RDATA=0x3344AABB. lh signed at 0x103 -> RDATA=0x000044AA; lhu at 0x101 -> 0x0000BBCC.
REQ-036 sw 0xDEADBEEF at 0x1FF -> byte stores (0x1FF,EF), (0x200,BE), (0x201,AD), (0x202,DE) on consecutive cycles; RSP at T+6.
REQ-037 IO lw at 0x11000000, MEM_DOUT2=0x0000ABCD -> single read at 0x11000000; RDATA=0x0000ABCD. IO sw at 0x11000004 -> one MEM_WRITE2 with address 0x11000004.
REQ-038 REQ_SIZE=3 -> no MEM_READ2/MEM_WRITE2; RSP_VALID at T+1 with RSP_ERR=1. Then drop RST_N during WRB after the second byte -> no further MEM_WRITE2, no RSP_VALID, REQ_READY=1.

Source files
------------

// File: rtl/mem_align_unit.sv
// Load/store alignment unit. Misaligned non-IO loads become two aligned word reads and
// misaligned non-IO stores become a burst of byte stores; IO accesses pass through unchanged.
module mem_align_unit #(
  parameter logic [31:0] IO_BASE = 32'h11000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic        MEM_SIGN,
  output logic [1:0]  MEM_SIZE,
  input  logic [31:0] MEM_DOUT2
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WR, WRB, RSP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        is_io;
  logic        span;
  logic [31:0] word0;
  logic [2:0]  n_bytes;

  function automatic logic spanning(input logic [31:0] a, input logic [1:0] sz);
    logic io;
    io = (a >= IO_BASE);
    return !io && (((sz == 2'd1) && (a[1:0] == 2'd3)) ||
                   ((sz == 2'd2) && (a[1:0] != 2'd0)));
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Little-endian window {hi,lo} starting at byte 'off' of lo, truncated then extended.
  function automatic logic [31:0] align_load(input logic [31:0] lo, input logic [31:0] hi,
                                             input logic [1:0] off, input logic [1:0] sz,
                                             input logic uns);
    logic [31:0] win;
    logic [31:0] r;
    win = 32'({hi, lo} >> {off, 3'b000});
    case (sz)
      2'd0:    r = uns ? {24'b0, win[7:0]}   : {{24{win[7]}}, win[7:0]};
      2'd1:    r = uns ? {16'b0, win[15:0]}  : {{16{win[15]}}, win[15:0]};
      default: r = win;
    endcase
    return r;
  endfunction

  assign is_io   = (addr_q >= IO_BASE);
  assign span    = spanning(addr_q, size_q);
  assign word0   = {addr_q[31:2], 2'b00};
  assign n_bytes = (size_q == 2'd2) ? 3'd4 : 3'd2;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    we_d       = we_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    REQ_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    RSP_RDATA  = 32'h0;
    RSP_ERR    = 1'b0;
    MEM_ADDR2  = 32'h0;
    MEM_DIN2   = 32'h0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    MEM_SIGN   = 1'b0;
    MEM_SIZE   = 2'd0;

    case (state_q)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          addr_d  = REQ_ADDR;
          size_d  = REQ_SIZE;
          we_d    = REQ_WE;
          uns_d   = REQ_UNSIGNED;
          wdata_d = REQ_WDATA;
          lo_d    = 32'h0;
          hi_d    = 32'h0;
          cnt_d   = 3'd0;
          if (REQ_SIZE == 2'd3)                   state_d = RSP;
          else if (!REQ_WE)                       state_d = RD0;
          else if (spanning(REQ_ADDR, REQ_SIZE))  state_d = WRB;
          else                                    state_d = WR;
        end
      end
      RD0: begin
        MEM_READ2 = 1'b1;
        if (is_io) begin
          MEM_ADDR2 = addr_q;
          MEM_SIZE  = size_q;
          MEM_SIGN  = uns_q;
        end else begin
          MEM_ADDR2 = word0;
          MEM_SIZE  = 2'd2;
        end
        state_d = RD1;
      end
      RD1: begin
        lo_d = MEM_DOUT2;
        if (span) begin
          MEM_READ2 = 1'b1;
          MEM_ADDR2 = word0 + 32'd4;
          MEM_SIZE  = 2'd2;
          state_d   = RD2;
        end else begin
          state_d = RSP;
        end
      end
      RD2: begin
        hi_d    = MEM_DOUT2;
        state_d = RSP;
      end
      WR: begin
        MEM_WRITE2 = 1'b1;
        MEM_ADDR2  = addr_q;
        MEM_SIZE   = size_q;
        MEM_DIN2   = wdata_q;
        MEM_SIGN   = uns_q;
        state_d    = RSP;
      end
      WRB: begin
        // One byte per cycle; the cycle with cnt == N is a settle cycle before RSP.
        if (cnt_q < n_bytes) begin
          MEM_WRITE2 = 1'b1;
          MEM_ADDR2  = addr_q + {29'b0, cnt_q};
          MEM_DIN2   = {24'b0, pick_byte(wdata_q, cnt_q[1:0])};
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d = RSP;
        end
      end
      RSP: begin
        RSP_VALID = 1'b1;
        RSP_ERR   = (size_q == 2'd3);
        if (!we_q && (size_q != 2'd3))
          RSP_RDATA = is_io ? lo_q : align_load(lo_q, hi_q, addr_q[1:0], size_q, uns_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      hi_q    <= 32'h0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit: scoreboard queues of expected memory strobes and
// responses, filled when a request is driven and drained by a negedge monitor.
module tb_mem_align_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WE = 1'b0;
  logic [31:0] REQ_ADDR = 32'h0;
  logic [1:0]  REQ_SIZE = 2'd0;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] REQ_WDATA = 32'h0;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic        MEM_SIGN;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_DOUT2 = 32'h0;

  mem_align_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
    .MEM_READ2(MEM_READ2), .MEM_SIGN(MEM_SIGN), .MEM_SIZE(MEM_SIZE),
    .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          c;
    logic        we;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] d;
    logic        sg;
  } mop_t;

  typedef struct {
    int          c;
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  mop_t mq[$];
  rsp_t rq[$];
  logic [31:0] mem [logic [31:0]];

  int ntest = 0;
  int nfail = 0;
  int cyc = 0;
  int t0 = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_a = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: data for a read seen in cycle C is presented throughout cycle C+1.
  always @(negedge CLK) begin
    rd_pend <= MEM_READ2;
    rd_a    <= MEM_ADDR2;
  end
  always @(posedge CLK) MEM_DOUT2 <= rd_pend ? memrd(rd_a) : 32'h0;

  always @(negedge CLK) begin : monitor
    mop_t m;
    rsp_t r;
    chk("rw_excl", {31'b0, MEM_READ2 & MEM_WRITE2}, 32'h0);
    if (MEM_READ2 || MEM_WRITE2) begin
      chk("mem_strobe_expected", {31'b0, mq.size() > 0}, 32'h1);
      if (mq.size() > 0) begin
        m = mq.pop_front();
        chk("mem_cycle", cyc, m.c);
        chk("mem_write", {31'b0, MEM_WRITE2}, {31'b0, m.we});
        chk("mem_addr", MEM_ADDR2, m.a);
        chk("mem_size", {30'b0, MEM_SIZE}, {30'b0, m.sz});
        chk("mem_din", MEM_DIN2, m.d);
        chk("mem_sign", {31'b0, MEM_SIGN}, {31'b0, m.sg});
      end
    end else begin
      chk("idle_addr", MEM_ADDR2, 32'h0);
      chk("idle_din", MEM_DIN2, 32'h0);
    end
    if (RSP_VALID) begin
      chk("rsp_expected", {31'b0, rq.size() > 0}, 32'h1);
      chk("rsp_not_ready", {31'b0, REQ_READY}, 32'h0);
      if (rq.size() > 0) begin
        r = rq.pop_front();
        chk("rsp_cycle", cyc, r.c);
        chk("rsp_rdata", RSP_RDATA, r.rd);
        chk("rsp_err", {31'b0, RSP_ERR}, {31'b0, r.err});
      end
    end
    if (!RST_N) chk("rst_ready", {31'b0, REQ_READY}, 32'h1);
  end

  task automatic em(input int dc, input logic we, input logic [31:0] a, input logic [1:0] sz,
                    input logic [31:0] d, input logic sg);
    mop_t m;
    m.c = t0 + dc; m.we = we; m.a = a; m.sz = sz; m.d = d; m.sg = sg;
    mq.push_back(m);
  endtask

  task automatic er(input int dc, input logic [31:0] rd, input logic err);
    rsp_t r;
    r.c = t0 + dc; r.rd = rd; r.err = err;
    rq.push_back(r);
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd);
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = a; REQ_SIZE = sz;
    REQ_UNSIGNED = uns; REQ_WDATA = wd;
    t0 = cyc;
    chk("req_ready", {31'b0, REQ_READY}, 32'h1);
  endtask

  // Deassert and scramble the request fields so only latched values can be used.
  task automatic release_req();
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_WE = ~REQ_WE; REQ_ADDR = 32'hFFFF_FFFF; REQ_SIZE = 2'd3;
    REQ_UNSIGNED = ~REQ_UNSIGNED; REQ_WDATA = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((mq.size() != 0 || rq.size() != 0) && n < 30) begin
      @(posedge CLK);
      n++;
    end
    chk("done_in_time", mq.size() + rq.size(), 32'h0);
    mq.delete();
    rq.delete();
  endtask

  initial begin
    mem[32'h100]       = 32'h11223344;
    mem[32'h11000000]  = 32'h0000ABCD;
    mem[32'h11000001]  = 32'h55667788;

    #2;
    chk("reset_ready", {31'b0, REQ_READY}, 32'h1);
    chk("reset_rsp_valid", {31'b0, RSP_VALID}, 32'h0);
    chk("reset_rdata", RSP_RDATA, 32'h0);
    chk("reset_err", {31'b0, RSP_ERR}, 32'h0);
    chk("reset_strobes", {30'b0, MEM_READ2, MEM_WRITE2}, 32'h0);
    chk("reset_size_sign", {29'b0, MEM_SIZE, MEM_SIGN}, 32'h0);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // lw aligned
    req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    em(1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0); er(3, 32'h11223344, 1'b0);
    release_req(); wait_done();

    mem[32'h100] = 32'hAABBCCDD;
    mem[32'h104] = 32'h11223344;

    // lw spanning, signed
    req(1'b0, 32'h102, 2'd2, 1'b0, 32'h0);
    em(1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0); em(2, 1'b0, 32'h104, 2'd2, 32'h0, 1'b0);
    er(4, 32'h3344AABB, 1'b0);
    release_req(); wait_done();

    // lh spanning, signed
    req(1'b0, 32'h103, 2'd1, 1'b0, 32'h0);
    em(1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0); em(2, 1'b0, 32'h104, 2'd2, 32'h0, 1'b0);
    er(4, 32'h000044AA, 1'b0);
    release_req(); wait_done();

    // lhu non-spanning at odd offset
    req(1'b0, 32'h101, 2'd1, 1'b1, 32'h0);
    em(1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0); er(3, 32'h0000BBCC, 1'b0);
    release_req(); wait_done();

    // lb signed, negative byte
    req(1'b0, 32'h101, 2'd0, 1'b0, 32'h0);
    em(1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0); er(3, 32'hFFFFFFCC, 1'b0);
    release_req(); wait_done();

    // lh signed aligned, negative half
    req(1'b0, 32'h100, 2'd1, 1'b0, 32'h0);
    em(1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0); er(3, 32'hFFFFCCDD, 1'b0);
    release_req(); wait_done();

    // lbu top byte
    req(1'b0, 32'h103, 2'd0, 1'b1, 32'h0);
    em(1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0); er(3, 32'h000000AA, 1'b0);
    release_req(); wait_done();

    // sw spanning -> four byte stores, response at T+6
    req(1'b1, 32'h1FF, 2'd2, 1'b0, 32'hDEADBEEF);
    em(1, 1'b1, 32'h1FF, 2'd0, 32'hEF, 1'b0); em(2, 1'b1, 32'h200, 2'd0, 32'hBE, 1'b0);
    em(3, 1'b1, 32'h201, 2'd0, 32'hAD, 1'b0); em(4, 1'b1, 32'h202, 2'd0, 32'hDE, 1'b0);
    er(6, 32'h0, 1'b0);
    release_req(); wait_done();

    // sh aligned, unsigned flag passes through on MEM_SIGN
    req(1'b1, 32'h200, 2'd1, 1'b1, 32'hCAFE1234);
    em(1, 1'b1, 32'h200, 2'd1, 32'hCAFE1234, 1'b1); er(2, 32'h0, 1'b0);
    release_req(); wait_done();

    // sh spanning -> two byte stores, response at T+4
    req(1'b1, 32'h203, 2'd1, 1'b0, 32'h0000BEEF);
    em(1, 1'b1, 32'h203, 2'd0, 32'hEF, 1'b0); em(2, 1'b1, 32'h204, 2'd0, 32'hBE, 1'b0);
    er(4, 32'h0, 1'b0);
    release_req(); wait_done();

    // IO lw
    req(1'b0, 32'h11000000, 2'd2, 1'b0, 32'h0);
    em(1, 1'b0, 32'h11000000, 2'd2, 32'h0, 1'b0); er(3, 32'h0000ABCD, 1'b0);
    release_req(); wait_done();

    // IO lw at misaligned address: one unmodified read, raw data returned
    req(1'b0, 32'h11000001, 2'd2, 1'b0, 32'h0);
    em(1, 1'b0, 32'h11000001, 2'd2, 32'h0, 1'b0); er(3, 32'h55667788, 1'b0);
    release_req(); wait_done();

    // IO sw
    req(1'b1, 32'h11000004, 2'd2, 1'b0, 32'h01020304);
    em(1, 1'b1, 32'h11000004, 2'd2, 32'h01020304, 1'b0); er(2, 32'h0, 1'b0);
    release_req(); wait_done();

    // illegal size: error response at T+1, no memory access
    req(1'b0, 32'h100, 2'd3, 1'b0, 32'h0);
    er(1, 32'h0, 1'b1);
    release_req(); wait_done();

    // reset during WRB after the second byte store
    req(1'b1, 32'h2FF, 2'd2, 1'b0, 32'hDEADBEEF);
    em(1, 1'b1, 32'h2FF, 2'd0, 32'hEF, 1'b0); em(2, 1'b1, 32'h300, 2'd0, 32'hBE, 1'b0);
    release_req();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("abort_ready", {31'b0, REQ_READY}, 32'h1);
    chk("abort_strobes", {30'b0, MEM_READ2, MEM_WRITE2}, 32'h0);
    repeat (4) @(posedge CLK);
    #1;
    chk("abort_writes_seen", mq.size(), 32'h0);
    chk("abort_no_rsp_pending", rq.size(), 32'h0);
    RST_N = 1'b1;

    // recovery after abort
    req(1'b0, 32'h104, 2'd2, 1'b0, 32'h0);
    em(1, 1'b0, 32'h104, 2'd2, 32'h0, 1'b0); er(3, 32'h11223344, 1'b0);
    release_req(); wait_done();

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
